// File: rtl/mac_operand_feeder_pkg.sv
// Shared definitions for the MAC operand feeder.
//   - Default operand width and MAC latency.
//   - Bit positions of the fields inside a buffered FIFO entry {last, b, a}.
//   - Width and wrap-around increment of the completed-vector counter.
package mac_operand_feeder_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int MAC_LAT_DEF = 1;
    localparam int VEC_CNT_W   = 8;

    // Entry layout, LSB first: a[DATA_W-1:0], b[DATA_W-1:0], last.
    function automatic int entry_a_lsb(input int data_w);
        return 0;
    endfunction

    function automatic int entry_b_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int entry_last_bit(input int data_w);
        return 2 * data_w;
    endfunction

    function automatic int entry_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // The counter wraps 255 -> 0 by plain modular addition.
    function automatic logic [VEC_CNT_W-1:0] vec_count_next(
        input logic [VEC_CNT_W-1:0] cur,
        input logic                 inc
    );
        return cur + VEC_CNT_W'(inc);
    endfunction

endpackage

// File: rtl/mac_operand_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered write-ready flag.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_valid   writer offers wr_data
//   wr_ready   registered "not full"; a write happens on wr_valid && wr_ready
//   wr_data    entry to store
//   rd_en      consumer wants the head entry this cycle
//   empty      no entry stored
//   rd_data    head entry (only meaningful when !empty)
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    // wr_ready is low while full, so a pop in the same cycle never lets a
    // write slip through; the slot reopens one cycle later.
    assign push     = wr_valid && ready_q;
    assign pop      = rd_en && (count != '0);
    assign empty    = (count == '0);
    assign wr_ready = ready_q;
    assign rd_data  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (PTR_W + 1)'(1);
            2'b01:   count_next = count - (PTR_W + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count   <= count_next;
            ready_q <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers (A,B) operand pairs and streams them into
// MAC_simple as vectors, flagging the first element of each vector with
// Clear_and_Mult and pulsing dot_done once the MAC output holds the result.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid/ready   operand source handshake
//   in_a, in_b       operand pair
//   in_last          pair closes its vector
//   mac_hold         downstream stall; bubbles are issued while high
//   Clear_and_Mult   to MAC: clear accumulator and start a new product
//   Data_A, Data_B   to MAC operands (zero during bubbles)
//   dot_done         one-cycle pulse when MAC Output_2 holds a finished vector
//   vec_count        completed vectors since reset, wrapping
module mac_operand_feeder
    import mac_operand_feeder_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int MAC_LAT = MAC_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_a,
    input  logic [DATA_W-1:0]    in_b,
    input  logic                 in_last,
    input  logic                 mac_hold,
    output logic                 Clear_and_Mult,
    output logic [DATA_W-1:0]    Data_A,
    output logic [DATA_W-1:0]    Data_B,
    output logic                 dot_done,
    output logic [VEC_CNT_W-1:0] vec_count
);

    localparam int EW     = entry_w(DATA_W);
    localparam int A_LSB  = entry_a_lsb(DATA_W);
    localparam int B_LSB  = entry_b_lsb(DATA_W);
    localparam int L_BIT  = entry_last_bit(DATA_W);

    logic [EW-1:0]        wr_entry;
    logic [EW-1:0]        head;
    logic                 fifo_empty;
    logic                 pop;
    logic [DATA_W-1:0]    head_a;
    logic [DATA_W-1:0]    head_b;
    logic                 head_last;

    logic [DATA_W-1:0]    data_a_p0;
    logic [DATA_W-1:0]    data_b_p0;
    logic                 clr_p0;
    logic                 first;
    // Bit 0 is registered alongside the issued element; the remaining
    // MAC_LAT bits model the MAC's own latency to Output_2.
    logic [MAC_LAT:0]     done_sr;
    logic [VEC_CNT_W-1:0] vec_count_q;

    always_comb begin
        wr_entry                       = '0;
        wr_entry[A_LSB +: DATA_W]      = in_a;
        wr_entry[B_LSB +: DATA_W]      = in_b;
        wr_entry[L_BIT]                = in_last;
    end

    assign head_a    = head[A_LSB +: DATA_W];
    assign head_b    = head[B_LSB +: DATA_W];
    assign head_last = head[L_BIT];
    assign pop       = !fifo_empty && !mac_hold;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (wr_entry),
        .rd_en    (!mac_hold),
        .empty    (fifo_empty),
        .rd_data  (head)
    );

    // Issue stage p0: head entry or a zero bubble onto the MAC operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_p0 <= '0;
            data_b_p0 <= '0;
            clr_p0    <= 1'b0;
            first     <= 1'b1;
        end else if (pop) begin
            data_a_p0 <= head_a;
            data_b_p0 <= head_b;
            clr_p0    <= first;
            first     <= head_last;
        end else begin
            // Bubble: the MAC adds 0, so a held or starved vector keeps
            // its partial sum and resumes without a clear.
            data_a_p0 <= '0;
            data_b_p0 <= '0;
            clr_p0    <= 1'b0;
        end
    end

    // Completion tracking: runs regardless of mac_hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sr     <= '0;
            vec_count_q <= '0;
        end else begin
            done_sr     <= {done_sr[MAC_LAT-1:0], pop && head_last};
            // Counts at the edge that raises dot_done, so vec_count already
            // includes the vector during its dot_done cycle.
            vec_count_q <= vec_count_next(vec_count_q, done_sr[MAC_LAT-1]);
        end
    end

    assign Clear_and_Mult = clr_p0;
    assign Data_A         = data_a_p0;
    assign Data_B         = data_b_p0;
    assign dot_done       = done_sr[MAC_LAT];
    assign vec_count      = vec_count_q;

endmodule
